// File: rtl/dac_tlv5618_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tlv5618_pkg
//  Description : Shared definitions for the TLV5618 two-channel update
//                scheduler: register-select codes, sequencer state encoding
//                and the 16-bit command word builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_tlv5618_pkg;

    // R1R0 register-select codes (code 2'b11 is never issued)
    localparam logic [1:0] c_r1r0_b_and_buf = 2'b00;  // write DAC B and buffer
    localparam logic [1:0] c_r1r0_buf       = 2'b01;  // write buffer only
    localparam logic [1:0] c_r1r0_a_upd_b   = 2'b10;  // write DAC A, load DAC B from buffer

    localparam int unsigned c_code_w = 12;

    // Sequencer states; START2/WAIT2 form the second pass of a paired update
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_START1 = 3'd2,
        ST_WAIT1  = 3'd3,
        ST_START2 = 3'd4,
        ST_WAIT2  = 3'd5
    } state_t;

    // Command word layout: D15 = R1, D14 = SPD, D13 = PWR, D12 = R0, D11..0 = code
    function automatic logic [15:0] build_word(
        input logic [1:0]          r1r0,
        input logic                spd,
        input logic                pwr,
        input logic [c_code_w-1:0] code
    );
        return {r1r0[1], spd, pwr, r1r0[0], code};
    endfunction

endpackage : dac_tlv5618_pkg
`default_nettype wire

// File: rtl/dac_tlv5618_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin arbiter. The grant is purely
//                combinational; the last-winner flag only moves when
//                update_en is high and a grant is actually issued.
//                The flag resets to "B", so A wins the first contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic update_en,
    output logic gnt_a,
    output logic gnt_b
);

    logic r_last_a;  // 1 = A was granted most recently, 0 = B

    // Grant A unless B is also requesting and A was served last
    always_comb begin
        gnt_a = req_a & (~req_b | ~r_last_a);
        gnt_b = req_b & ~gnt_a;
    end

    // Remember the most recent winner when the owner commits to a grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_a <= 1'b0;
        end else if (update_en && (gnt_a || gnt_b)) begin
            r_last_a <= gnt_a;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dac_tlv5618_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tlv5618_sched
//  Description : Two-channel update scheduler for the TLV5618 serial DAC.
//                Arbitrates channel A/B sample requests, builds 16-bit
//                command words and hands them to the dac_tlv5618 serializer.
//                Paired mode writes B into the buffer first, then writes A
//                with a buffer-to-B load so both outputs change together.
//                A watchdog abandons a word whose completion never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_tlv5618_sched
    import dac_tlv5618_pkg::*;
#(
    parameter logic        FastMode   = 1'b1,
    parameter int unsigned TimeoutMax = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_en,
    input  logic        pwr_down,
    input  logic        a_valid,
    input  logic [11:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [11:0] b_data,
    output logic        b_ready,
    output logic        dac_start,
    output logic [15:0] dac_data,
    input  logic        dac_done,
    output logic        busy,
    output logic        err
);

    // Watchdog counter only needs to reach TimeoutMax-1 (the last WAIT cycle)
    localparam int unsigned c_cnt_w = (TimeoutMax > 1) ? $clog2(TimeoutMax) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TimeoutMax - 1);

    state_t              r_state;
    state_t              w_state_next;

    logic                w_gnt_a;
    logic                w_gnt_b;
    logic                w_arb_update;
    logic                w_timeout;

    logic                r_paired;     // sequence in progress is a paired update
    logic                r_sel_a;      // independent sequence serves channel A
    logic                r_pwr;        // PWR bit captured in GRANT
    logic [11:0]         r_a_code;     // A code captured in GRANT, used by the second word
    logic [15:0]         r_dac_data;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_err;

    logic [15:0]         w_first_word;
    logic [15:0]         w_second_word;

    // ------------------------------------------------------------------------
    // Round-robin arbiter; only consulted for independent updates
    // ------------------------------------------------------------------------
    assign w_arb_update = (r_state == ST_IDLE) && !sync_en;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (a_valid),
        .req_b     (b_valid),
        .update_en (w_arb_update),
        .gnt_a     (w_gnt_a),
        .gnt_b     (w_gnt_b)
    );

    // ------------------------------------------------------------------------
    // Command word construction
    // ------------------------------------------------------------------------

    // First word is built from the live inputs during GRANT, as the
    // requesters still hold their data until the accept pulse completes
    always_comb begin
        if (r_paired) begin
            w_first_word = build_word(c_r1r0_buf, FastMode, pwr_down, b_data);
        end else if (r_sel_a) begin
            w_first_word = build_word(c_r1r0_a_upd_b, FastMode, pwr_down, a_data);
        end else begin
            w_first_word = build_word(c_r1r0_b_and_buf, FastMode, pwr_down, b_data);
        end
    end

    // Second word of a paired update comes from the codes latched in GRANT
    always_comb begin
        w_second_word = build_word(c_r1r0_a_upd_b, FastMode, r_pwr, r_a_code);
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, accept pulses, serializer start and busy flag
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        dac_start    = 1'b0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (sync_en ? (a_valid && b_valid) : (w_gnt_a || w_gnt_b)) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                a_ready      = r_paired || r_sel_a;
                b_ready      = r_paired || !r_sel_a;
                w_state_next = ST_START1;
            end
            ST_START1: begin
                dac_start    = 1'b1;
                w_state_next = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (dac_done) begin
                    w_state_next = r_paired ? ST_START2 : ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    // Abandon the whole sequence, including any pending A word
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_START2: begin
                dac_start    = 1'b1;
                w_state_next = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (dac_done) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: mode capture, code latching, output word, watchdog
    // ------------------------------------------------------------------------

    // Capture sequence context and load the output word on START entry only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_paired   <= 1'b0;
            r_sel_a    <= 1'b0;
            r_pwr      <= 1'b0;
            r_a_code   <= '0;
            r_dac_data <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_paired <= sync_en;
                    r_sel_a  <= w_gnt_a;
                end
                ST_GRANT: begin
                    r_a_code   <= a_data;
                    r_pwr      <= pwr_down;
                    r_dac_data <= w_first_word;
                end
                ST_WAIT1: begin
                    if (w_state_next == ST_START2) begin
                        r_dac_data <= w_second_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Watchdog: cleared while starting a word so WAIT begins at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_START1 || r_state == ST_START2) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT1 || r_state == ST_WAIT2) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Error pulse appears in the first IDLE cycle after an abandoned word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign dac_data = r_dac_data;
    assign err      = r_err;

endmodule : dac_tlv5618_sched
`default_nettype wire

// File: tb/tb_dac_tlv5618_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_tlv5618_sched
//  Description : Self-checking bench for dac_tlv5618_sched. Expected command
//                words and grant order come from a reference model built on
//                the word format and round-robin rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_tlv5618_sched;

    localparam int unsigned TO   = 16;
    localparam bit          FAST = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        sync_en;
    logic        pwr_down;
    logic        a_valid;
    logic [11:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [11:0] b_data;
    logic        b_ready;
    logic        dac_start;
    logic [15:0] dac_data;
    logic        dac_done;
    logic        busy;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_starts     = 0;
    bit m_last_a     = 1'b0;   // reference model: 1 = A won the last contention

    dac_tlv5618_sched #(
        .FastMode   (FAST),
        .TimeoutMax (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_en   (sync_en),
        .pwr_down  (pwr_down),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .dac_start (dac_start),
        .dac_data  (dac_data),
        .dac_done  (dac_done),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count serializer start pulses
    always @(negedge clk) begin
        if (dac_start) n_starts++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // kind: 0 = write B and buffer, 1 = buffer only, 2 = write A and load B
    function automatic logic [15:0] model_word(input int kind, input bit pw, input logic [11:0] code);
        int r1;
        int r0;
        r1 = kind / 2;
        r0 = kind % 2;
        return 16'(r1 * 32768 + int'(FAST) * 16384 + int'(pw) * 8192 + r0 * 4096 + int'(code));
    endfunction

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_word(input int d);
        repeat (d) @(negedge clk);
        dac_done = 1'b1;
        @(negedge clk);
        dac_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync_en = 1'b0; pwr_down = 1'b0; dac_done = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
        tests_run++; if (b_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
        tests_run++; if (dac_start !== 1'b0) begin tests_failed++; $display("FAIL reset_dac_start: got %b expected 0", dac_start); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        tests_run++; if (dac_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_dac_data: got %h expected 0000", dac_data); end
        rst_n = 1'b1;
        m_last_a = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 14; r++) begin
            bit          pa, pb, pw, ok;
            logic [11:0] ca, cb;
            bit          order[$];
            if (r < 2) begin
                pa = 1'b1; pb = 1'b1; ca = 12'h0AA; cb = 12'h055; pw = 1'b0;
            end else begin
                pa = 1'($urandom_range(0, 1));
                pb = 1'($urandom_range(0, 1));
                if (!pa && !pb) pb = 1'b1;
                ca = 12'($urandom); cb = 12'($urandom);
                pw = 1'($urandom_range(0, 1));
            end
            order.delete();
            if (pa && pb) begin
                order.push_back(!m_last_a);
                order.push_back(m_last_a);
            end else begin
                order.push_back(pa);
            end
            sync_en = 1'b0; pwr_down = pw;
            a_data = ca; b_data = cb; a_valid = pa; b_valid = pb;
            foreach (order[i]) begin
                bit          e;
                logic [15:0] w;
                int          d;
                e = order[i];
                w = e ? model_word(2, pw, ca) : model_word(0, pw, cb);
                wait_grant(ok);
                tests_run++;
                if (!ok || {a_ready, b_ready} !== (e ? 2'b10 : 2'b01)) begin
                    tests_failed++;
                    $display("FAIL rr_grant round %0d: got ready %b%b expected %b", r, a_ready, b_ready, (e ? 2'b10 : 2'b01));
                end
                m_last_a = e;
                @(negedge clk);
                if (e) a_valid = 1'b0; else b_valid = 1'b0;
                tests_run++;
                if (dac_start !== 1'b1 || dac_data !== w) begin
                    tests_failed++;
                    $display("FAIL rr_word round %0d: got start %b data %h expected start 1 data %h", r, dac_start, dac_data, w);
                end
                d = $urandom_range(1, 5);
                repeat (d) @(negedge clk);
                tests_run++;
                if (dac_data !== w || busy !== 1'b1 || dac_start !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_hold round %0d: got data %h busy %b expected data %h busy 1", r, dac_data, busy, w);
                end
                finish_word(0);
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_done round %0d: got busy %b expected 0", r, busy);
                end
            end
            a_valid = 1'b0; b_valid = 1'b0;
        end
    endtask

    task automatic test_single();
        bit ok;
        sync_en = 1'b0; pwr_down = 1'b0;
        @(negedge clk);
        a_data = 12'h123; a_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got %b%b expected 10", a_ready, b_ready);
        end
        @(negedge clk);
        a_valid = 1'b0;
        tests_run++;
        if (dac_start !== 1'b1 || dac_data !== 16'hC123) begin
            tests_failed++;
            $display("FAIL single_word: got start %b data %h expected start 1 data c123", dac_start, dac_data);
        end
        m_last_a = 1'b1;
        finish_word(3);
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got busy %b err %b expected 0 0", busy, err);
        end
        ok = 1'b1;
    endtask

    task automatic test_paired();
        bit ok;
        int s0;
        sync_en = 1'b1; pwr_down = 1'b0;
        a_data = 12'hFFF; a_valid = 1'b1; b_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || a_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL paired_wait_both: got busy %b a_ready %b expected 0 0", busy, a_ready);
        end
        b_data = 12'h800; b_valid = 1'b1;
        wait_grant(ok);
        tests_run++;
        if (!ok || {a_ready, b_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL paired_ready: got %b%b expected 11", a_ready, b_ready);
        end
        s0 = n_starts;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        tests_run++;
        if (dac_start !== 1'b1 || dac_data !== 16'h5800) begin
            tests_failed++;
            $display("FAIL paired_word1: got start %b data %h expected start 1 data 5800", dac_start, dac_data);
        end
        finish_word(2);
        tests_run++;
        if (dac_start !== 1'b1 || dac_data !== 16'hCFFF || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL paired_word2: got start %b data %h expected start 1 data cfff", dac_start, dac_data);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (n_starts - s0 !== 2) begin
            tests_failed++;
            $display("FAIL paired_start_count: got %0d expected 2", n_starts - s0);
        end
        finish_word(0);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL paired_done: got busy %b expected 0", busy);
        end
        for (int r = 0; r < 4; r++) begin
            logic [11:0] ca, cb;
            bit          pw;
            ca = 12'($urandom); cb = 12'($urandom); pw = 1'($urandom_range(0, 1));
            pwr_down = pw; a_data = ca; b_data = cb; a_valid = 1'b1; b_valid = 1'b1;
            wait_grant(ok);
            tests_run++;
            if (!ok || {a_ready, b_ready} !== 2'b11) begin
                tests_failed++;
                $display("FAIL paired_rand_ready %0d: got %b%b expected 11", r, a_ready, b_ready);
            end
            @(negedge clk);
            a_valid = 1'b0; b_valid = 1'b0; pwr_down = ~pw;
            if (r % 2 == 1) sync_en = 1'b0;
            tests_run++;
            if (dac_start !== 1'b1 || dac_data !== model_word(1, pw, cb)) begin
                tests_failed++;
                $display("FAIL paired_rand_w1 %0d: got %h expected %h", r, dac_data, model_word(1, pw, cb));
            end
            finish_word($urandom_range(1, 4));
            tests_run++;
            if (dac_start !== 1'b1 || dac_data !== model_word(2, pw, ca)) begin
                tests_failed++;
                $display("FAIL paired_rand_w2 %0d: got start %b data %h expected %h", r, dac_start, dac_data, model_word(2, pw, ca));
            end
            finish_word($urandom_range(1, 4));
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL paired_rand_done %0d: got busy %b expected 0", r, busy);
            end
            sync_en = 1'b1;
        end
        sync_en = 1'b0; pwr_down = 1'b0;
    endtask

    task automatic test_pwr_down();
        bit ok;
        sync_en = 1'b0; pwr_down = 1'b1;
        b_data = 12'h001; b_valid = 1'b1;
        wait_grant(ok);
        tests_run++;
        if (!ok || {a_ready, b_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL pwr_ready: got %b%b expected 01", a_ready, b_ready);
        end
        m_last_a = 1'b0;
        @(negedge clk);
        b_valid = 1'b0; pwr_down = 1'b0;
        tests_run++;
        if (dac_start !== 1'b1 || dac_data !== 16'h6001) begin
            tests_failed++;
            $display("FAIL pwr_word: got start %b data %h expected start 1 data 6001", dac_start, dac_data);
        end
        finish_word(2);
    endtask

    task automatic test_timeout();
        bit          ok, seen;
        int          n, s0;
        logic [11:0] cb;
        sync_en = 1'b0; pwr_down = 1'b0;
        a_data = 12'($urandom); a_valid = 1'b1;
        wait_grant(ok);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0; seen = 1'b0;
        for (int k = 0; k < int'(TO) + 8; k++) begin
            @(negedge clk);
            n++;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen || n != int'(TO) + 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err: got seen %b after %0d cycles busy %b expected err after %0d cycles busy 0", seen, n, busy, TO + 1);
        end
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: got err %b expected 0", err);
        end
        cb = 12'($urandom);
        b_data = cb; b_valid = 1'b1;
        wait_grant(ok);
        @(negedge clk);
        b_valid = 1'b0;
        tests_run++;
        if (!ok || dac_start !== 1'b1 || dac_data !== model_word(0, 1'b0, cb)) begin
            tests_failed++;
            $display("FAIL timeout_recover: got start %b data %h expected start 1 data %h", dac_start, dac_data, model_word(0, 1'b0, cb));
        end
        finish_word(1);
        sync_en = 1'b1;
        a_data = 12'($urandom); b_data = 12'($urandom); a_valid = 1'b1; b_valid = 1'b1;
        wait_grant(ok);
        s0 = n_starts;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < int'(TO) + 8; k++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (!seen || n_starts - s0 !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_paired: got err seen %b starts %0d busy %b expected 1 1 0", seen, n_starts - s0, busy);
        end
        sync_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        sync_en = 1'b0;
        a_data = 12'($urandom); a_valid = 1'b1;
        wait_grant(ok);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_ready, b_ready, dac_start, busy, err} !== 5'b0 || dac_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got rdy %b%b start %b busy %b err %b data %h expected all 0",
                     a_ready, b_ready, dac_start, busy, err, dac_data);
        end
        rst_n = 1'b1;
        m_last_a = 1'b0;
        finish_word(1);
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || dac_start !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_late_done: got busy %b start %b err %b expected 0 0 0", busy, dac_start, err);
        end
        a_valid = 1'b1; b_valid = 1'b1;
        wait_grant(ok);
        tests_run++;
        if (!ok || {a_ready, b_ready} !== (m_last_a ? 2'b01 : 2'b10)) begin
            tests_failed++;
            $display("FAIL midreset_first_grant: got %b%b expected 10", a_ready, b_ready);
        end
        @(negedge clk);
        a_valid = 1'b0;
        finish_word(1);
        wait_grant(ok);
        @(negedge clk);
        b_valid = 1'b0;
        finish_word(1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_paired();
        test_pwr_down();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dac_tlv5618_sched
`default_nettype wire
